// File: rtl/pipeline_controller_if.sv
// Decode/Execute/Memory/Writeback control bundle for pipeline_controller.
// The master side drives instruction fields and hazard controls. The slave side
// (the controller) returns decoded and pipelined control bits.
interface pipeline_controller_if #(
  parameter int ALUCTRL_W = 3
);
  // Decode-stage inputs
  logic [5:0]           OpcodeD;
  logic [5:0]           FunctD;
  logic                 EqualD;
  // Hazard-unit controls for the Execute register
  logic                 StallE;
  logic                 FlushE;
  // Decode-stage combinational outputs
  logic                 PCSrcD;
  logic                 JumpD;
  logic                 ZeroExtD;
  logic                 IllegalD;
  // Execute-stage control
  logic                 RegWriteE;
  logic                 MemtoRegE;
  logic                 ALUSrcE;
  logic                 RegDstE;
  logic [ALUCTRL_W-1:0] ALUControlE;
  // Memory-stage control
  logic                 RegWriteM;
  logic                 MemtoRegM;
  logic                 MemWriteM;
  // Writeback-stage control
  logic                 RegWriteW;
  logic                 MemtoRegW;

  modport master (
    output OpcodeD, FunctD, EqualD, StallE, FlushE,
    input  PCSrcD, JumpD, ZeroExtD, IllegalD,
    input  RegWriteE, MemtoRegE, ALUSrcE, RegDstE, ALUControlE,
    input  RegWriteM, MemtoRegM, MemWriteM,
    input  RegWriteW, MemtoRegW
  );

  modport slave (
    input  OpcodeD, FunctD, EqualD, StallE, FlushE,
    output PCSrcD, JumpD, ZeroExtD, IllegalD,
    output RegWriteE, MemtoRegE, ALUSrcE, RegDstE, ALUControlE,
    output RegWriteM, MemtoRegM, MemWriteM,
    output RegWriteW, MemtoRegW
  );
endinterface

// File: rtl/pipeline_controller.sv
// MIPS-style pipeline controller. It decodes the instruction in Decode and
// carries its control bits through the Execute, Memory and Writeback registers.
// Execute can be held or bubbled by the hazard unit. Memory and Writeback
// always advance.
module pipeline_controller #(
  parameter int ALUCTRL_W    = 3,   // 3..8
  parameter int EN_BNE       = 1,
  parameter int EN_IMM_LOGIC = 1
) (
  input logic                 clk,
  input logic                 reset,
  pipeline_controller_if.slave bus
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_ANDI  = 6'b001100,
    OP_ORI   = 6'b001101,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef enum logic [5:0] {
    FN_ADD = 6'b100000,
    FN_SUB = 6'b100010,
    FN_AND = 6'b100100,
    FN_OR  = 6'b100101,
    FN_SLT = 6'b101010
  } funct_e;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_e;

  // Control bits that travel from Decode into the Execute register.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
    logic alu_src;
    logic reg_dst;
    alu_e alu;
  } ctrl_t;

  // A bubble has every enable clear. The ALU code rests at add so that an
  // idle Execute stage looks like a harmless add.
  localparam ctrl_t CTRL_NOP = '{
    reg_write:  1'b0,
    mem_to_reg: 1'b0,
    mem_write:  1'b0,
    alu_src:    1'b0,
    reg_dst:    1'b0,
    alu:        ALU_ADD
  };

  ctrl_t dec;
  logic  branch;
  logic  branch_ne;
  logic  jump;
  logic  zero_ext;
  logic  illegal;

  ctrl_t e_q;
  logic  m_reg_write_q;
  logic  m_mem_to_reg_q;
  logic  m_mem_write_q;
  logic  w_reg_write_q;
  logic  w_mem_to_reg_q;

  // Decode the opcode and funct into control bits. Any illegal or disabled
  // encoding is squashed to a bubble.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    dec       = CTRL_NOP;
    branch    = 1'b0;
    branch_ne = 1'b0;
    jump      = 1'b0;
    zero_ext  = 1'b0;
    illegal   = 1'b0;

    case (bus.OpcodeD)
      OP_RTYPE: begin
        dec.reg_write = 1'b1;
        dec.reg_dst   = 1'b1;
        case (bus.FunctD)
          FN_ADD:  dec.alu = ALU_ADD;
          FN_SUB:  dec.alu = ALU_SUB;
          FN_AND:  dec.alu = ALU_AND;
          FN_OR:   dec.alu = ALU_OR;
          FN_SLT:  dec.alu = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      OP_LW: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OP_BEQ: begin
        branch  = 1'b1;
        dec.alu = ALU_SUB;
      end
      OP_BNE: begin
        if (EN_BNE != 0) begin
          branch_ne = 1'b1;
          dec.alu   = ALU_SUB;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_ADDI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        if (EN_IMM_LOGIC != 0) begin
          dec.reg_write = 1'b1;
          dec.alu_src   = 1'b1;
          zero_ext      = 1'b1;
          dec.alu       = (bus.OpcodeD == OP_ANDI) ? ALU_AND : ALU_OR;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_J:    jump    = 1'b1;
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      dec       = CTRL_NOP;
      branch    = 1'b0;
      branch_ne = 1'b0;
      jump      = 1'b0;
      zero_ext  = 1'b0;
    end
  end

  assign bus.PCSrcD   = (branch & bus.EqualD) | (branch_ne & ~bus.EqualD);
  assign bus.JumpD    = jump;
  assign bus.ZeroExtD = zero_ext;
  assign bus.IllegalD = illegal;

  // Execute register: reset and flush both load a bubble, and flush beats stall.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge.
    if (reset || bus.FlushE) begin
      e_q <= CTRL_NOP;
    end else if (!bus.StallE) begin
      e_q <= dec;
    end
  end

  // Memory register always follows Execute. A stalled E is copied again, and
  // the hazard unit is left to suppress that duplicate.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_reg_write_q  <= 1'b0;
      m_mem_to_reg_q <= 1'b0;
      m_mem_write_q  <= 1'b0;
    end else begin
      m_reg_write_q  <= e_q.reg_write;
      m_mem_to_reg_q <= e_q.mem_to_reg;
      m_mem_write_q  <= e_q.mem_write;
    end
  end

  // Writeback register always follows Memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_reg_write_q  <= 1'b0;
      w_mem_to_reg_q <= 1'b0;
    end else begin
      w_reg_write_q  <= m_reg_write_q;
      w_mem_to_reg_q <= m_mem_to_reg_q;
    end
  end

  assign bus.RegWriteE   = e_q.reg_write;
  assign bus.MemtoRegE   = e_q.mem_to_reg;
  assign bus.ALUSrcE     = e_q.alu_src;
  assign bus.RegDstE     = e_q.reg_dst;
  assign bus.ALUControlE = ALUCTRL_W'(e_q.alu);

  assign bus.RegWriteM   = m_reg_write_q;
  assign bus.MemtoRegM   = m_mem_to_reg_q;
  assign bus.MemWriteM   = m_mem_write_q;

  assign bus.RegWriteW   = w_reg_write_q;
  assign bus.MemtoRegW   = w_mem_to_reg_q;

endmodule
